// File: rtl/da_dct_pkg.sv
// Shared types and elaboration-time helpers for the odd-path DA DCT engine.
package da_dct_pkg;

  typedef enum logic [2:0] {S_LOAD, S_BFLY, S_FETCH, S_ACC, S_OUT} state_e;

  function automatic int d_w(input int in_w);
    return in_w + 1;
  endfunction

  function automatic int rom_w(input int coef_w, input int n);
    return coef_w + $clog2(n / 2);
  endfunction

  function automatic int acc_w(input int coef_w, input int n, input int in_w);
    return rom_w(coef_w, n) + d_w(in_w);
  endfunction

  // Round-half-away-from-zero of 2^frac * cos((2m+1)(2k+1)pi/(2n)).
  function automatic int coef(input int n, input int k, input int m, input int frac);
    real v;
    v = (2.0 ** frac) * $cos(real'((2 * m + 1) * (2 * k + 1)) * 3.14159265358979323846 / real'(2 * n));
    if (v >= 0.0) return $rtoi(v + 0.5);
    else return -$rtoi(0.5 - v);
  endfunction

endpackage

// File: rtl/da_coef_rom.sv
// DA coefficient ROM: word = sum of C[k][m] over the set address bits m.
module da_coef_rom
  import da_dct_pkg::*;
#(
  parameter int N         = 16,
  parameter int COEF_W    = 16,
  parameter int COEF_FRAC = 14,
  localparam int KW       = $clog2(N / 2),
  localparam int RW       = rom_w(COEF_W, N)
) (
  input  logic [N/2-1:0]        addr_i,
  input  logic [KW-1:0]         k_i,
  output logic signed [RW-1:0]  word_o
);

  logic signed [RW-1:0] tab [N/2][N/2];

  for (genvar gk = 0; gk < N / 2; gk++) begin : g_k
    for (genvar gm = 0; gm < N / 2; gm++) begin : g_m
      localparam int C = coef(N, gk, gm, COEF_FRAC);
      assign tab[gk][gm] = RW'(C);
    end
  end

  // Constant table plus address mask folds to a per-k ROM in synthesis.
  always_comb begin
    word_o = '0;
    for (int m = 0; m < N / 2; m++)
      if (addr_i[m]) word_o = word_o + tab[k_i][m];
  end

endmodule

// File: rtl/da_dct_odd_engine.sv
// Bit-serial DA engine for the odd DCT-II outputs X[2k+1] of one N-point block.
// Define DA_SAT_EN to clamp out-of-range results; otherwise results wrap.
module da_dct_odd_engine
  import da_dct_pkg::*;
#(
  parameter int N         = 16,
  parameter int IN_W      = 15,
  parameter int COEF_W    = 16,
  parameter int COEF_FRAC = 14,
  parameter int OUT_W     = 18,
  localparam int KW       = $clog2(N / 2)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic [KW-1:0]           out_idx,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    busy
);

  localparam int NH    = N / 2;
  localparam int D_W   = d_w(IN_W);
  localparam int ROM_W = rom_w(COEF_W, N);
  localparam int ACC_W = acc_w(COEF_W, N, IN_W);
  localparam int CW    = $clog2(N);
  localparam int BW    = $clog2(D_W);

  state_e                   state_q;
  logic signed [IN_W-1:0]   x_q [N];
  logic signed [D_W-1:0]    d_q [NH];
  logic [CW-1:0]            cnt_q;
  logic [BW-1:0]            b_q;
  logic [KW-1:0]            k_q;
  logic [NH-1:0]            addr_q, addr_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d, term;
  logic signed [ROM_W-1:0]  rom_word;
  logic signed [OUT_W-1:0]  out_d, out_data_q;
  logic [KW-1:0]            out_idx_q;
  logic                     out_valid_q, out_last_q, in_ready_q, busy_q;

  da_coef_rom #(.N(N), .COEF_W(COEF_W), .COEF_FRAC(COEF_FRAC)) u_rom (
    .addr_i (addr_q),
    .k_i    (k_q),
    .word_o (rom_word)
  );

  always_comb begin
    addr_d = '0;
    for (int m = 0; m < NH; m++) addr_d[m] = d_q[m][b_q];
  end

  // The sign bit plane of d carries negative weight.
  always_comb begin
    term  = ACC_W'(rom_word);
    if (b_q == BW'(D_W - 1)) term = -term;
    acc_d = acc_q + (term <<< b_q);
  end

`ifdef DA_SAT_EN
  localparam logic signed [ACC_W-1:0] OMAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] OMIN = ~OMAX;
  logic signed [ACC_W-1:0] res;
  always_comb begin
    res = acc_d >>> COEF_FRAC;
    if (res > OMAX)      out_d = {1'b0, {(OUT_W-1){1'b1}}};
    else if (res < OMIN) out_d = {1'b1, {(OUT_W-1){1'b0}}};
    else                 out_d = res[OUT_W-1:0];
  end
`else
  always_comb out_d = OUT_W'(acc_d >>> COEF_FRAC);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_LOAD;
      cnt_q       <= '0;
      b_q         <= '0;
      k_q         <= '0;
      addr_q      <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      for (int i = 0; i < N; i++)  x_q[i] <= '0;
      for (int m = 0; m < NH; m++) d_q[m] <= '0;
    end else begin
      case (state_q)
        S_LOAD: if (in_valid) begin
          x_q[cnt_q] <= in_data;
          cnt_q      <= cnt_q + 1'b1;
          if (cnt_q == CW'(N - 1)) begin
            cnt_q      <= '0;
            state_q    <= S_BFLY;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        S_BFLY: begin
          for (int m = 0; m < NH; m++) d_q[m] <= D_W'(x_q[m]) - D_W'(x_q[N-1-m]);
          acc_q   <= '0;
          b_q     <= '0;
          state_q <= S_FETCH;
        end
        S_FETCH: begin
          addr_q  <= addr_d;
          state_q <= S_ACC;
        end
        S_ACC: begin
          acc_q <= acc_d;
          if (b_q == BW'(D_W - 1)) begin
            state_q     <= S_OUT;
            out_valid_q <= 1'b1;
            out_data_q  <= out_d;
            out_idx_q   <= k_q;
            out_last_q  <= (k_q == KW'(NH - 1));
          end else begin
            b_q     <= b_q + 1'b1;
            state_q <= S_FETCH;
          end
        end
        S_OUT: if (out_ready) begin
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
          if (k_q != KW'(NH - 1)) begin
            k_q     <= k_q + 1'b1;
            acc_q   <= '0;
            b_q     <= '0;
            state_q <= S_FETCH;
          end else begin
            k_q        <= '0;
            state_q    <= S_LOAD;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;

endmodule
